// File: rtl/m_and_tree_pipe_pkg.sv
// rtl/m_and_tree_pipe_pkg.sv - mode enum and tree-geometry helpers for m_and_tree_pipe
package p_and_tree;

    typedef enum logic [1:0] {
        MODE_AND  = 2'd0,
        MODE_OR   = 2'd1,
        MODE_NAND = 2'd2,
        MODE_NOR  = 2'd3
    } mode_e;

    // Number of FANIN-ary levels needed to reduce width inputs to one bit.
    function automatic int clog_fanin(input int width, input int fanin);
        int lv;
        int span;
        lv   = 0;
        span = 1;
        while (span < width) begin
            span = span * fanin;
            lv   = lv + 1;
        end
        return lv;
    endfunction

    // Node count at the output of lvl levels (lvl=0 is the leaf row).
    function automatic int level_width(input int width, input int fanin, input int lvl);
        int w;
        w = width;
        for (int i = 0; i < lvl; i++) begin
            w = (w + fanin - 1) / fanin;
        end
        return w;
    endfunction

    // Registered stage count: one register every reg_every levels, last level always registered.
    function automatic int num_stages(input int width, input int fanin, input int reg_every);
        return (clog_fanin(width, fanin) + reg_every - 1) / reg_every;
    endfunction

    // OR/NOR are built as De Morgan duals of the AND tree.
    function automatic logic entry_invert(input mode_e m);
        return (m == MODE_OR) || (m == MODE_NOR);
    endfunction

    function automatic logic exit_invert(input mode_e m);
        return (m == MODE_OR) || (m == MODE_NAND);
    endfunction

endpackage

// File: rtl/m_and_tree_pipe_level.sv
// rtl/m_and_tree_pipe_level.sv - one level of FANIN-ary AND nodes with optional output register
module m_and_tree_level
    import p_and_tree::*;
#(
    parameter int IN_W  = 9,
    parameter int FANIN = 4,
    parameter int OUT_W = 3,
    parameter bit REG   = 1'b1
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             in_valid,
    input  mode_e            in_mode,
    input  logic [IN_W-1:0]  in_data,
    output logic             out_valid,
    output mode_e            out_mode,
    output logic [OUT_W-1:0] out_data
);

    localparam int PAD_W = OUT_W * FANIN;

    logic [PAD_W-1:0] padded;
    logic [OUT_W-1:0] node;

    // Empty leaf slots read as 1 so they never pull an AND node low.
    always_comb begin
        padded             = '1;
        padded[IN_W-1:0]   = in_data;
    end

    for (genvar n = 0; n < OUT_W; n++) begin : g_node
        assign node[n] = &padded[n*FANIN +: FANIN];
    end

    if (REG) begin : g_reg
        logic             valid_q, valid_d;
        mode_e            mode_q, mode_d;
        logic [OUT_W-1:0] data_q, data_d;

        // Data and mode only advance on valid beats so the stage holds its last result.
        always_comb begin
            valid_d = in_valid;
            mode_d  = mode_q;
            data_d  = data_q;
            if (in_valid) begin
                mode_d = in_mode;
                data_d = node;
            end
        end

        // Stage register; reset leaves an AND/zero result so the final output reads 0.
        always_ff @(posedge clk) begin
            if (!resetn) begin
                valid_q <= 1'b0;
                mode_q  <= MODE_AND;
                data_q  <= '0;
            end else begin
                valid_q <= valid_d;
                mode_q  <= mode_d;
                data_q  <= data_d;
            end
        end

        assign out_valid = valid_q;
        assign out_mode  = mode_q;
        assign out_data  = data_q;
    end else begin : g_comb
        logic unused_clk_rst;

        assign unused_clk_rst = clk ^ resetn;
        assign out_valid      = in_valid;
        assign out_mode       = in_mode;
        assign out_data       = node;
    end

endmodule

// File: rtl/m_and_tree_pipe.sv
// rtl/m_and_tree_pipe.sv - pipelined wide AND/OR/NAND/NOR reduction with HOLD qualifier (STICKY_CAPTURE_EN adds sticky capture)
module m_and_tree_pipe
    import p_and_tree::*;
#(
    parameter int WIDTH     = 9,
    parameter int FANIN     = 4,
    parameter int REG_EVERY = 1,
    parameter int HOLD      = 2
) (
    input  logic             MasterClock,
    input  logic             RESETL,
    input  logic             IN_VALID,
    input  logic [WIDTH-1:0] A,
    input  logic [1:0]       MODE,
    output logic             OUT_VALID,
    output logic             B,
    output logic             B_QUAL
`ifdef STICKY_CAPTURE_EN
    ,
    output logic             STICKY,
    input  logic             STICKY_CLR
`endif
);

    localparam int LEVELS = clog_fanin(WIDTH, FANIN);
    localparam int CNT_W  = $clog2(HOLD + 1);
    localparam logic [CNT_W-1:0] HOLD_C = CNT_W'(HOLD);

    mode_e            mode_in;
    logic [WIDTH-1:0] entry_data;
    logic             fin_and;
    logic             fin_valid;
    mode_e            fin_mode;

    assign mode_in    = mode_e'(MODE);
    assign entry_data = entry_invert(mode_in) ? ~A : A;

    for (genvar i = 0; i < LEVELS; i++) begin : g_lvl
        localparam int IW       = level_width(WIDTH, FANIN, i);
        localparam int OW       = level_width(WIDTH, FANIN, i + 1);
        localparam bit REG_HERE = (((i + 1) % REG_EVERY) == 0) || (i == LEVELS - 1);

        logic [IW-1:0] din;
        logic          vin;
        mode_e         mdin;
        logic [OW-1:0] dout;
        logic          vout;
        mode_e         mdout;

        if (i == 0) begin : g_src
            assign din  = entry_data;
            assign vin  = IN_VALID;
            assign mdin = mode_in;
        end else begin : g_src
            assign din  = g_lvl[i-1].dout;
            assign vin  = g_lvl[i-1].vout;
            assign mdin = g_lvl[i-1].mdout;
        end

        m_and_tree_level #(
            .IN_W  (IW),
            .FANIN (FANIN),
            .OUT_W (OW),
            .REG   (REG_HERE)
        ) u_level (
            .clk       (MasterClock),
            .resetn    (RESETL),
            .in_valid  (vin),
            .in_mode   (mdin),
            .in_data   (din),
            .out_valid (vout),
            .out_mode  (mdout),
            .out_data  (dout)
        );
    end

    assign fin_and   = g_lvl[LEVELS-1].dout;
    assign fin_valid = g_lvl[LEVELS-1].vout;
    assign fin_mode  = g_lvl[LEVELS-1].mdout;

    // The final level is registered, so B is a registered value through one XOR.
    assign OUT_VALID = fin_valid;
    assign B         = fin_and ^ exit_invert(fin_mode);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             b_qual_q, b_qual_d;

    // Count consecutive true results, saturating at HOLD; a false result restarts the run.
    always_comb begin
        cnt_d = cnt_q;
        if (OUT_VALID) begin
            if (B) begin
                cnt_d = (cnt_q == HOLD_C) ? cnt_q : cnt_q + 1'b1;
            end else begin
                cnt_d = '0;
            end
        end
        b_qual_d = (cnt_d == HOLD_C);
    end

    // Qualifier state register.
    always_ff @(posedge MasterClock) begin
        if (!RESETL) begin
            cnt_q    <= '0;
            b_qual_q <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            b_qual_q <= b_qual_d;
        end
    end

    assign B_QUAL = b_qual_q;

`ifdef STICKY_CAPTURE_EN
    logic sticky_q, sticky_d;

    // Capture any qualified cycle; a pending set overrides a clear.
    always_comb begin
        sticky_d = sticky_q;
        if (b_qual_q) begin
            sticky_d = 1'b1;
        end else if (STICKY_CLR) begin
            sticky_d = 1'b0;
        end
    end

    // Sticky flag register.
    always_ff @(posedge MasterClock) begin
        if (!RESETL) begin
            sticky_q <= 1'b0;
        end else begin
            sticky_q <= sticky_d;
        end
    end

    assign STICKY = sticky_q;
`endif

endmodule

// File: tb/tb_m_and_tree_pipe.sv
// tb/tb_m_and_tree_pipe.sv - self-checking bench for m_and_tree_pipe across a parameter sweep
module tb_m_and_tree_pipe;

    localparam int NCFG = 25;
    localparam int HOLD = 2;
    localparam int HMAX = 1024;
    localparam logic [1:0] M_AND  = 2'd0;
    localparam logic [1:0] M_OR   = 2'd1;
    localparam logic [1:0] M_NAND = 2'd2;
    localparam logic [1:0] M_NOR  = 2'd3;

    // Config 0 is the default build; 1..24 sweep WIDTH x FANIN x REG_EVERY.
    function automatic int cfg_w(input int k);
        if (k == 0) return 9;
        case ((k - 1) / 6)
            0:       return 2;
            1:       return 16;
            2:       return 17;
            default: return 64;
        endcase
    endfunction

    function automatic int cfg_f(input int k);
        if (k == 0) return 4;
        case (((k - 1) / 2) % 3)
            0:       return 2;
            1:       return 4;
            default: return 5;
        endcase
    endfunction

    function automatic int cfg_r(input int k);
        if (k == 0) return 1;
        return ((k - 1) % 2) + 1;
    endfunction

    function automatic int stages_of(input int w, input int f, input int r);
        int     l;
        longint span;
        l    = 0;
        span = 1;
        while (span < w) begin
            span = span * f;
            l    = l + 1;
        end
        return (l + r - 1) / r;
    endfunction

    function automatic logic ref_b(input logic [63:0] a, input int w, input logic [1:0] m);
        logic [63:0] mask;
        logic        all1;
        logic        any1;
        mask = (w >= 64) ? {64{1'b1}} : ((64'd1 << w) - 64'd1);
        all1 = ((a & mask) == mask);
        any1 = ((a & mask) != 64'd0);
        case (m)
            M_AND:   return all1;
            M_OR:    return any1;
            M_NAND:  return !all1;
            default: return !any1;
        endcase
    endfunction

    logic        clk = 1'b0;
    logic        resetn_drv;
    logic        v_drv;
    logic [63:0] a_drv;
    logic [1:0]  m_drv;
    logic        ov_o [NCFG];
    logic        b_o  [NCFG];
    logic        bq_o [NCFG];
`ifdef STICKY_CAPTURE_EN
    logic        clr_drv;
    logic        st_o [NCFG];
`endif

    always #5 clk = ~clk;

    for (genvar k = 0; k < NCFG; k++) begin : g_dut
        localparam int W = cfg_w(k);
        localparam int F = cfg_f(k);
        localparam int R = cfg_r(k);
        logic ov, b, bq;
`ifdef STICKY_CAPTURE_EN
        logic st;
        assign st_o[k] = st;
`endif
        m_and_tree_pipe #(
            .WIDTH     (W),
            .FANIN     (F),
            .REG_EVERY (R),
            .HOLD      (HOLD)
        ) u_dut (
            .MasterClock (clk),
            .RESETL      (resetn_drv),
            .IN_VALID    (v_drv),
            .A           (a_drv[W-1:0]),
            .MODE        (m_drv),
            .OUT_VALID   (ov),
            .B           (b),
            .B_QUAL      (bq)
`ifdef STICKY_CAPTURE_EN
            ,
            .STICKY      (st),
            .STICKY_CLR  (clr_drv)
`endif
        );
        assign ov_o[k] = ov;
        assign b_o[k]  = b;
        assign bq_o[k] = bq;
    end

    int          checks = 0;
    int          errors = 0;
    int          n = 0;
    int          floor_idx = 0;
    logic        hist_v [HMAX];
    logic [63:0] hist_a [HMAX];
    logic [1:0]  hist_m [HMAX];
    int          stg      [NCFG];
    logic        b_last   [NCFG];
    int          cnt_m    [NCFG];
    logic        qual_m   [NCFG];
    logic        qual_cur [NCFG];
    logic        sticky_m [NCFG];

    task automatic chk(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %b expected %b", tag, obs, exp);
        end
    endtask

    // One clock: record the beat, advance, then compare every instance with the model.
    task automatic step();
        logic ov_e;
        int   idx;
        if (n >= HMAX) begin
            $display("FAIL history_overflow observed %0d expected below %0d", n, HMAX);
            $fatal(1);
        end
        hist_v[n] = resetn_drv & v_drv;
        hist_a[n] = a_drv;
        hist_m[n] = m_drv;
        @(posedge clk);
        #1;
        if (!resetn_drv) floor_idx = n + 1;
        for (int k = 0; k < NCFG; k++) begin
            if (!resetn_drv) begin
                b_last[k]   = 1'b0;
                cnt_m[k]    = 0;
                qual_m[k]   = 1'b0;
                qual_cur[k] = 1'b0;
                sticky_m[k] = 1'b0;
            end else begin
`ifdef STICKY_CAPTURE_EN
                if (qual_cur[k]) sticky_m[k] = 1'b1;
                else if (clr_drv) sticky_m[k] = 1'b0;
`endif
                qual_cur[k] = qual_m[k];
            end
            idx  = n + 1 - stg[k];
            ov_e = (idx >= floor_idx) ? hist_v[idx] : 1'b0;
            if (ov_e) b_last[k] = ref_b(hist_a[idx], cfg_w(k), hist_m[idx]);
            chk($sformatf("cfg%0d_out_valid step%0d", k, n), ov_o[k], ov_e);
            chk($sformatf("cfg%0d_b step%0d", k, n), b_o[k], b_last[k]);
            chk($sformatf("cfg%0d_b_qual step%0d", k, n), bq_o[k], qual_cur[k]);
`ifdef STICKY_CAPTURE_EN
            chk($sformatf("cfg%0d_sticky step%0d", k, n), st_o[k], sticky_m[k]);
`endif
            if (ov_e) cnt_m[k] = b_last[k] ? ((cnt_m[k] + 1 > HOLD) ? HOLD : cnt_m[k] + 1) : 0;
            qual_m[k] = (cnt_m[k] == HOLD);
        end
        n++;
    endtask

    task automatic drive(input logic v, input logic [63:0] a, input logic [1:0] m);
        v_drv = v;
        a_drv = a;
        m_drv = m;
        step();
    endtask

    initial begin
        logic [63:0] ra;
        resetn_drv = 1'b0;
        v_drv      = 1'b0;
        a_drv      = '0;
        m_drv      = M_AND;
`ifdef STICKY_CAPTURE_EN
        clr_drv    = 1'b0;
`endif
        for (int k = 0; k < NCFG; k++) begin
            stg[k]      = stages_of(cfg_w(k), cfg_f(k), cfg_r(k));
            b_last[k]   = 1'b0;
            cnt_m[k]    = 0;
            qual_m[k]   = 1'b0;
            qual_cur[k] = 1'b0;
            sticky_m[k] = 1'b0;
        end

        // Reset state.
        step();
        step();
        chk("reset_out_valid", ov_o[0], 1'b0);
        chk("reset_b", b_o[0], 1'b0);
        chk("reset_b_qual", bq_o[0], 1'b0);
        resetn_drv = 1'b1;

        // Default latency of two and qualification after the second true beat.
        drive(1'b1, {64{1'b1}}, M_AND);
        chk("lat_t1_out_valid", ov_o[0], 1'b0);
        drive(1'b1, {64{1'b1}}, M_AND);
        chk("lat_t2_out_valid", ov_o[0], 1'b1);
        chk("lat_t2_b", b_o[0], 1'b1);
        drive(1'b0, '0, M_AND);
        chk("lat_t3_out_valid", ov_o[0], 1'b1);
        chk("lat_t3_b_qual", bq_o[0], 1'b0);
        drive(1'b0, '0, M_AND);
        chk("lat_t4_out_valid", ov_o[0], 1'b0);
        chk("lat_t4_b_qual", bq_o[0], 1'b1);

        // Walking zero in AND then NAND.
        for (int k = 0; k < 9; k++) drive(1'b1, ~(64'd1 << k), M_AND);
        for (int k = 0; k < 9; k++) drive(1'b1, ~(64'd1 << k), M_NAND);
        drive(1'b0, '0, M_AND);
        drive(1'b0, '0, M_AND);

        // OR / NOR corners.
        drive(1'b1, 64'h0, M_OR);
        drive(1'b1, 64'h100, M_OR);
        chk("or_zero_b", b_o[0], 1'b0);
        drive(1'b1, 64'h0, M_NOR);
        chk("or_msb_b", b_o[0], 1'b1);
        drive(1'b0, '0, M_AND);
        chk("nor_zero_b", b_o[0], 1'b1);
        drive(1'b0, '0, M_AND);
        chk("idle_hold_b", b_o[0], 1'b1);
        chk("idle_out_valid", ov_o[0], 1'b0);

        // Back-to-back beats with the mode changing every beat.
        for (int i = 0; i < 12; i++) drive(1'b1, {$urandom, $urandom}, 2'(i % 4));

        // Qualifier pattern 1,1,idle,idle,1,0,1.
        drive(1'b1, 64'h0, M_AND);
        drive(1'b1, {64{1'b1}}, M_AND);
        drive(1'b1, {64{1'b1}}, M_AND);
        drive(1'b0, '0, M_AND);
        drive(1'b0, '0, M_AND);
        chk("qual_rise", bq_o[0], 1'b1);
        drive(1'b1, {64{1'b1}}, M_AND);
        chk("qual_hold_idle", bq_o[0], 1'b1);
        drive(1'b1, 64'h0, M_AND);
        drive(1'b1, {64{1'b1}}, M_AND);
        drive(1'b0, '0, M_AND);
        drive(1'b0, '0, M_AND);
        chk("qual_fall", bq_o[0], 1'b0);
        drive(1'b0, '0, M_AND);
        chk("qual_stay_low", bq_o[0], 1'b0);

`ifdef STICKY_CAPTURE_EN
        // Clear asserted while the qualifier is still high: set wins.
        drive(1'b1, {64{1'b1}}, M_AND);
        drive(1'b1, {64{1'b1}}, M_AND);
        drive(1'b0, '0, M_AND);
        drive(1'b0, '0, M_AND);
        clr_drv = 1'b1;
        drive(1'b0, '0, M_AND);
        drive(1'b0, '0, M_AND);
        chk("sticky_collision", st_o[0], 1'b1);
        drive(1'b1, 64'h0, M_AND);
        for (int i = 0; i < 4; i++) drive(1'b0, '0, M_AND);
        chk("sticky_cleared", st_o[0], 1'b0);
        clr_drv = 1'b0;
`endif

        // Reset one cycle after a valid beat discards it.
        drive(1'b1, {64{1'b1}}, M_AND);
        resetn_drv = 1'b0;
        drive(1'b0, '0, M_AND);
        resetn_drv = 1'b1;
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, '0, M_AND);
            chk($sformatf("midreset_out_valid%0d", i), ov_o[0], 1'b0);
        end
        chk("midreset_b", b_o[0], 1'b0);
        chk("midreset_b_qual", bq_o[0], 1'b0);

        // Randomised beats with occasional resets across all configurations.
        for (int i = 0; i < 400; i++) begin
            case ($urandom_range(0, 4))
                0:       ra = {$urandom, $urandom};
                1:       ra = {64{1'b1}};
                2:       ra = 64'h0;
                3:       ra = ~(64'd1 << $urandom_range(0, 63));
                default: ra = 64'd1 << $urandom_range(0, 63);
            endcase
            resetn_drv = ($urandom_range(0, 59) != 0);
`ifdef STICKY_CAPTURE_EN
            clr_drv = ($urandom_range(0, 7) == 0);
`endif
            drive($urandom_range(0, 3) != 0, ra, 2'($urandom_range(0, 3)));
        end
        resetn_drv = 1'b1;
        for (int i = 0; i < 8; i++) drive(1'b0, '0, M_AND);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
